// File: rtl/run_detect_arbiter.sv
// Round-robin arbiter with a per-tenure run detector on the owner's serial bit.
// Z1/Z2 flag a run of ones ending or continuing. hit_cnt counts continuations in each tenure.
module run_detect_arbiter #(
    parameter int N_REQ    = 4,
    parameter int RUN_LEN  = 2,
    parameter int MAX_HOLD = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ-1:0]         done,
    input  logic [N_REQ-1:0]         X_in,
    output logic [N_REQ-1:0]         gnt,
    output logic [$clog2(N_REQ)-1:0] gnt_id,
    output logic                     busy,
    output logic                     Ya,
    output logic                     Yb,
    output logic                     Yc,
    output logic                     Z1,
    output logic                     Z2,
    output logic [3:0]               hit_cnt
);

    localparam int ID_W = $clog2(N_REQ);

    typedef enum logic [1:0] {
        S_IDLE,
        S_GRANT,
        S_RELEASE
    } state_t;

    state_t            r_state;
    logic [ID_W-1:0]   r_rr_ptr;
    logic [ID_W-1:0]   r_owner;
    logic [N_REQ-1:0]  r_gnt;
    logic              r_busy;
    logic [3:0]        r_run_cnt;
    logic [3:0]        r_hit_cnt;
    logic [7:0]        r_hold_cnt;

    logic              w_found;
    logic [ID_W-1:0]   w_pick;
    logic              w_x_own;
    logic              w_release;
    logic [ID_W-1:0]   w_next_ptr;

    // Scan from the highest offset down so the lowest offset at or above rr_ptr wins.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req[(int'(r_rr_ptr) + i) % N_REQ]) begin
                w_found = 1'b1;
                w_pick  = ID_W'((int'(r_rr_ptr) + i) % N_REQ);
            end
        end
    end

    assign w_x_own    = X_in[r_owner];
    assign w_release  = done[r_owner] | ~req[r_owner] | (r_hold_cnt == 8'(MAX_HOLD - 1));
    assign w_next_ptr = (int'(r_owner) == N_REQ - 1) ? '0 : r_owner + 1'b1;

    assign Ya = r_busy & (r_run_cnt == 4'd0);
    assign Yb = r_busy & (r_run_cnt != 4'd0) & (r_run_cnt < 4'(RUN_LEN));
    assign Yc = r_busy & (r_run_cnt == 4'(RUN_LEN));
    assign Z1 = Yc & ~w_x_own;
    assign Z2 = Yc & w_x_own;

    assign gnt     = r_gnt;
    assign busy    = r_busy;
    assign gnt_id  = r_owner;
    assign hit_cnt = r_hit_cnt;

    // NOTE: every register here uses <= so all next-state terms see pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_rr_ptr   <= '0;
            r_owner    <= '0;
            r_gnt      <= '0;
            r_busy     <= 1'b0;
            r_run_cnt  <= 4'd0;
            r_hit_cnt  <= 4'd0;
            r_hold_cnt <= 8'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_state    <= S_GRANT;
                        r_owner    <= w_pick;
                        r_gnt      <= N_REQ'(1) << w_pick;
                        r_busy     <= 1'b1;
                        r_run_cnt  <= 4'd0;
                        r_hit_cnt  <= 4'd0;
                        r_hold_cnt <= 8'd0;
                    end
                end
                S_GRANT: begin
                    r_hold_cnt <= r_hold_cnt + 8'd1;
                    if (Z2 && r_hit_cnt != 4'd15)
                        r_hit_cnt <= r_hit_cnt + 4'd1;
                    if (!w_x_own)
                        r_run_cnt <= 4'd0;
                    else if (r_run_cnt < 4'(RUN_LEN))
                        r_run_cnt <= r_run_cnt + 4'd1;
                    if (w_release) begin
                        r_state  <= S_RELEASE;
                        r_gnt    <= '0;
                        r_busy   <= 1'b0;
                        r_rr_ptr <= w_next_ptr;
                    end
                end
                S_RELEASE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_run_detect_arbiter.sv
// Self-checking bench for run_detect_arbiter: directed scenarios plus randomized traffic
// compared every cycle against a tenure-level reference model.
module tb_run_detect_arbiter;

    localparam int N_REQ    = 4;
    localparam int RUN_LEN  = 2;
    localparam int MAX_HOLD = 8;
    localparam int ID_W     = $clog2(N_REQ);

    logic             clk   = 1'b0;
    logic             reset = 1'b0;
    logic [N_REQ-1:0] req   = '0;
    logic [N_REQ-1:0] done  = '0;
    logic [N_REQ-1:0] X_in  = '0;
    logic [N_REQ-1:0] gnt;
    logic [ID_W-1:0]  gnt_id;
    logic             busy, Ya, Yb, Yc, Z1, Z2;
    logic [3:0]       hit_cnt;

    run_detect_arbiter #(.N_REQ(N_REQ), .RUN_LEN(RUN_LEN), .MAX_HOLD(MAX_HOLD)) dut (
        .clk(clk), .reset(reset), .req(req), .done(done), .X_in(X_in),
        .gnt(gnt), .gnt_id(gnt_id), .busy(busy),
        .Ya(Ya), .Yb(Yb), .Yc(Yc), .Z1(Z1), .Z2(Z2), .hit_cnt(hit_cnt)
    );

    always #10 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: who owns the resource, how long they have held it, how long
    // the current run of ones is, how many continuations were seen, and where the
    // next search starts. m_gap marks the one dead cycle after a tenure.
    bit m_busy, m_gap;
    int m_owner, m_ptr, m_run, m_hits, m_held;

    int grant_log[$];
    int start_log[$];
    int len_log[$];
    bit prev_busy;
    int cur_len;
    int cyc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_gap = 0; m_owner = 0; m_ptr = 0;
        m_run = 0; m_hits = 0; m_held = 0;
        prev_busy = 0; cur_len = 0;
        grant_log.delete(); start_log.delete(); len_log.delete();
    endtask

    task automatic compare_all();
        bit yc;
        bit xo;
        yc = m_busy && (m_run == RUN_LEN);
        xo = X_in[m_owner];
        check("gnt",     32'(gnt),     m_busy ? 32'(1 << m_owner) : 32'd0);
        check("busy",    32'(busy),    32'(m_busy));
        if (m_busy) check("gnt_id", 32'(gnt_id), 32'(m_owner));
        check("Ya",      32'(Ya),      32'(m_busy && m_run == 0));
        check("Yb",      32'(Yb),      32'(m_busy && m_run > 0 && m_run < RUN_LEN));
        check("Yc",      32'(Yc),      32'(yc));
        check("Z1",      32'(Z1),      32'(yc && !xo));
        check("Z2",      32'(Z2),      32'(yc && xo));
        check("hit_cnt", 32'(hit_cnt), 32'(m_hits));
    endtask

    task automatic model_step();
        if (m_gap) begin
            m_gap = 0;
        end else if (!m_busy) begin
            for (int k = 0; k < N_REQ; k++) begin
                int i;
                i = (m_ptr + k) % N_REQ;
                if (req[i]) begin
                    m_busy = 1; m_owner = i; m_held = 0; m_run = 0; m_hits = 0;
                    break;
                end
            end
        end else begin
            bit x;
            x = X_in[m_owner];
            if (m_run == RUN_LEN && x) m_hits = (m_hits < 15) ? m_hits + 1 : 15;
            m_run = x ? ((m_run + 1 < RUN_LEN) ? m_run + 1 : RUN_LEN) : 0;
            m_held++;
            if (done[m_owner] || !req[m_owner] || m_held == MAX_HOLD) begin
                m_busy = 0; m_gap = 1; m_ptr = (m_owner + 1) % N_REQ;
            end
        end
    endtask

    // One clock cycle: called at the falling edge with inputs already driven.
    task automatic tick();
        #1;
        compare_all();
        if (busy && !prev_busy) begin
            grant_log.push_back(int'(gnt));
            start_log.push_back(cyc);
            cur_len = 0;
        end
        if (busy) cur_len++;
        if (!busy && prev_busy) len_log.push_back(cur_len);
        prev_busy = busy;
        model_step();
        cyc++;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        req = '0; done = '0; X_in = '0;
        reset = 1'b1;
        #1;
        model_reset();
        compare_all();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        cyc = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bit seq [6];
        int exp_order [5];
        int h;
        bit pulsed;
        seq       = '{1, 1, 0, 1, 1, 1};
        exp_order = '{1, 2, 4, 8, 1};

        @(negedge clk);

        // Single requester, run detection, done release.
        do_reset();
        req = 4'b0001;
        tick();
        for (int i = 0; i < 6; i++) begin
            X_in = {3'b000, seq[i]};
            #1;
            if (i == 0) check("t1_gnt_latency", 32'(gnt), 32'd1);
            if (i == 2) check("t1_yc_after_two", 32'(Yc), 32'd1);
            if (i == 2) check("t1_z1_on_zero", 32'(Z1), 32'd1);
            if (i == 5) check("t1_z2_first", 32'(Z2), 32'd1);
            tick();
        end
        done = 4'b0001;
        #1;
        check("t1_z2_second", 32'(Z2), 32'd1);
        tick();
        done = '0;
        #1;
        check("t1_release_busy", 32'(busy), 32'd0);
        check("t1_hit_cnt", 32'(hit_cnt), 32'd2);
        tick();
        tick();

        // All requesters held: rotation and hold expiry.
        do_reset();
        req = 4'b1111;
        repeat (52) tick();
        check("t2_grants_seen", 32'(grant_log.size() >= 5), 32'd1);
        for (int k = 0; k < 5 && k < grant_log.size(); k++)
            check("t2_order", 32'(grant_log[k]), 32'(exp_order[k]));
        for (int k = 0; k < len_log.size(); k++)
            check("t2_tenure_len", 32'(len_log[k]), 32'(MAX_HOLD));
        for (int k = 0; k + 1 < start_log.size(); k++)
            check("t2_period", 32'(start_log[k+1] - start_log[k]), 32'(MAX_HOLD + 2));

        // Non-owner done pulse is ignored.
        do_reset();
        req = 4'b0110;
        pulsed = 0;
        repeat (24) begin
            if (!pulsed && busy && gnt == 4'b0100) begin
                done = 4'b0010;
                pulsed = 1;
            end
            tick();
            done = '0;
        end
        check("t3_pulsed", 32'(pulsed), 32'd1);
        check("t3_second_owner", (grant_log.size() > 1) ? 32'(grant_log[1]) : 32'd0, 32'd4);
        check("t3_len", (len_log.size() > 1) ? 32'(len_log[1]) : 32'd0, 32'(MAX_HOLD));

        // Owner drops req mid-tenure with X_in high.
        do_reset();
        req = 4'b0001; X_in = 4'b1111;
        repeat (6) tick();
        req = '0;
        tick();
        #1;
        check("t4_release_busy", 32'(busy), 32'd0);
        check("t4_release_y", 32'({Ya, Yb, Yc, Z1, Z2}), 32'd0);
        h = int'(hit_cnt);
        check("t4_hits", 32'(h), 32'd4);
        tick();
        tick();
        check("t4_hit_hold", 32'(hit_cnt), 32'(h));

        // Asynchronous reset in the middle of a tenure.
        do_reset();
        req = 4'b0001;
        repeat (4) tick();
        #2;
        reset = 1'b1;
        #1;
        check("t5_async_gnt", 32'(gnt), 32'd0);
        check("t5_async_busy", 32'(busy), 32'd0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        cyc = 0;
        req = 4'b1000;
        tick();
        #1;
        check("t5_wrap_gnt", 32'(gnt), 32'h8);
        check("t5_wrap_id", 32'(gnt_id), 32'd3);
        tick();

        // Z outputs follow X_in combinationally while Yc is set.
        do_reset();
        req = 4'b0001; X_in = 4'b0001;
        repeat (3) tick();
        #1;
        check("t6_yc", 32'(Yc), 32'd1);
        X_in = 4'b0001; #1;
        check("t6_z2_hi", 32'({Z1, Z2}), 32'b01);
        X_in = 4'b1110; #1;
        check("t6_z1_lo", 32'({Z1, Z2}), 32'b10);
        X_in = 4'b0001; #1;
        check("t6_z2_back", 32'({Z1, Z2}), 32'b01);
        tick();
        X_in = '0;
        tick();

        // Randomized traffic against the model.
        do_reset();
        for (int n = 0; n < 1500; n++) begin
            if (n % 12 == 0) req = N_REQ'($urandom);
            else if ($urandom_range(0, 9) == 0) req = req ^ N_REQ'(1 << $urandom_range(0, N_REQ - 1));
            done = ($urandom_range(0, 5) == 0) ? N_REQ'($urandom) : '0;
            X_in = ($urandom_range(0, 3) == 0) ? N_REQ'($urandom) : N_REQ'($urandom) | X_in;
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
